alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 88 ++++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end sharing one combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 always wins); default is round-robin.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_ina,
    output logic [WIDTH-1:0] alu_inb,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    input  logic             resp_ready
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t           state;
    logic             gnt;
    logic             last;
    logic             pick1;
    logic             take;
    logic [OPW-1:0]   op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
`ifdef ALU_ARB_FIXED_PRIO_EN
    assign pick1 = req1_valid && !req0_valid;
`else
    assign pick1 = req1_valid && (!req0_valid || !last);
`endif
    // rst gates ready directly: the async reset holds state at IDLE, which alone would not block it
    assign take       = state == IDLE && !rst && (req0_valid || req1_valid);
    assign req0_ready = take && !pick1;
    assign req1_ready = take && pick1;
    assign alu_op     = op_r;
    assign alu_ina    = a_r;
    assign alu_inb    = b_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last       <= 1'b1;
            op_r       <= '0;
            a_r        <= '0;
            b_r        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    gnt   <= pick1;
                    op_r  <= pick1 ? req1_op : req0_op;
                    a_r   <= pick1 ? req1_a : req0_a;
                    b_r   <= pick1 ? req1_b : req0_b;
                    state <= EXEC;
                end
                EXEC: begin
                    resp_data  <= alu_out;
                    resp_zero  <= alu_zero;
                    resp_id    <= gnt;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    last       <= resp_id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready, resp_valid, resp_id, resp_zero, alu_zero;
    logic [3:0]  alu_op;
    logic [31:0] alu_ina, alu_inb, alu_out, resp_data;
    int          checks = 0;
    int          errors = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0011: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b0100: return a << b[4:0];
            4'b1001: return $unsigned($signed(a) >>> b[4:0]);
            4'b0111: return {31'b0, a < b};
            4'b1000: return {31'b0, $signed(a) < $signed(b)};
            default: return a ^ 32'hA5A5_0000 ^ {28'b0, op};
        endcase
    endfunction

    assign alu_out  = alu_ref(alu_op, alu_ina, alu_inb);
    assign alu_zero = alu_out == 32'd0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb), .alu_out(alu_out), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_zero(resp_zero),
        .resp_ready(resp_ready)
    );

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // one uncontested req0 transaction with immediate consumption, starting from IDLE
    task automatic run_req0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
        checks++;
        if ({resp_valid, resp_id, resp_zero} !== 3'b000 || resp_data !== 32'd0) begin
            errors++; $display("FAIL reset_resp got v=%b id=%b z=%b d=%h exp all 0", resp_valid, resp_id, resp_zero, resp_data);
        end
        checks++;
        if (alu_op !== 4'd0 || alu_ina !== 32'd0 || alu_inb !== 32'd0) begin
            errors++; $display("FAIL reset_alu got op=%h a=%h b=%h exp 0", alu_op, alu_ina, alu_inb);
        end
        @(negedge clk);
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || alu_op !== 4'b0010 || alu_ina !== 32'd5 || alu_inb !== 32'd7) begin
            errors++; $display("FAIL single_exec got v=%b op=%h a=%h b=%h exp v=0 op=2 a=5 b=7", resp_valid, alu_op, alu_ina, alu_inb);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd12 || resp_zero !== 1'b0 || resp_id !== 1'b0) begin
            errors++; $display("FAIL single_resp got v=%b d=%0d z=%b id=%b exp v=1 d=12 z=0 id=0", resp_valid, resp_data, resp_zero, resp_id);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_done got v=%b exp=0", resp_valid); end
    endtask

    task automatic test_alternate();
        logic exp_id;
        pulse_reset();
        req0_op = 4'b0110; req0_a = 32'd9;    req0_b = 32'd9;
        req1_op = 4'b0011; req1_a = 32'hF0;   req1_b = 32'h0F;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            exp_id = FIXED ? 1'b0 : g[0];
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL alt_grant%0d got r1r0=%b exp id=%b", g, {req1_ready, req0_ready}, exp_id);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_data !== (exp_id ? 32'hFF : 32'd0) || resp_zero !== !exp_id) begin
                errors++; $display("FAIL alt_resp%0d got v=%b id=%b d=%h z=%b exp id=%b", g, resp_valid, resp_id, resp_data, resp_zero, exp_id);
            end
            if (g == 2) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            @(negedge clk);
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_stall();
        logic        exp_id;
        logic [31:0] exp_d;
        exp_id = FIXED ? 1'b0 : 1'b1;
        exp_d  = exp_id ? 32'hFF : 32'd0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL stall_grant got r1r0=%b exp id=%b", {req1_ready, req0_ready}, exp_id);
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp_d || resp_id !== exp_id || {req0_ready, req1_ready} !== 2'b00) begin
                errors++; $display("FAIL stall_hold%0d got v=%b d=%h id=%b rdy=%b exp v=1 d=%h id=%b rdy=00",
                                   k, resp_valid, resp_data, resp_id, {req0_ready, req1_ready}, exp_d, exp_id);
            end
            @(negedge clk);
        end
        resp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL stall_release got v=%b exp=0", resp_valid); end
    endtask

    task automatic test_reset_mid();
        run_req0(4'b0000, 32'hFF, 32'h0F);
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd2;
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || alu_ina !== 32'd0 || alu_op !== 4'd0) begin
            errors++; $display("FAIL rstmid_async got v=%b a=%h op=%h exp 0", resp_valid, alu_ina, alu_op);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_noresp%0d got v=%b exp=0", k, resp_valid); end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_grant got r1r0=%b exp=01", {req1_ready, req0_ready}); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_sra_drop();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'h1; req0_b = 32'h2;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd3; req1_b = 32'd4;
        #1;
        checks++;
        if (req1_ready !== 1'b0) begin errors++; $display("FAIL drop_busy got r1=%b exp=0", req1_ready); end
        @(negedge clk);
        req1_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin errors++; $display("FAIL drop_noresp%0d got v=%b exp=0", k, resp_valid); end
        end
        req1_valid = 1'b1; req1_op = 4'b1001; req1_a = 32'h8000_0000; req1_b = 32'd4;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL sra_grant got r1r0=%b exp=10", {req1_ready, req0_ready}); end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'hF800_0000 || resp_id !== 1'b1 || resp_zero !== 1'b0) begin
            errors++; $display("FAIL sra_resp got v=%b d=%h id=%b z=%b exp v=1 d=f8000000 id=1 z=0", resp_valid, resp_data, resp_id, resp_zero);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    // transaction model: at most one operation outstanding, response visible from two cycles after its ready cycle
    task automatic test_random();
        logic [3:0]  ops[12] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0101,
                                 4'b0100, 4'b1001, 4'b0111, 4'b1000, 4'b1111, 4'b1010};
        bit          pending = 1'b0, last_m = 1'b1, exp_id = 1'b0, any, win, ev;
        int          acc_i = 0;
        logic [3:0]  e_op = '0;
        logic [31:0] e_a = '0, e_b = '0, e_d;
        pulse_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ev = pending && i >= acc_i + 2;
            e_d = alu_ref(e_op, e_a, e_b);
            checks++;
            if (resp_valid !== ev) begin errors++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, resp_valid, ev); end
            if (ev) begin
                checks++;
                if (resp_data !== e_d || resp_id !== exp_id || resp_zero !== (e_d == 32'd0)) begin
                    errors++; $display("FAIL rnd_resp i=%0d got d=%h id=%b z=%b exp d=%h id=%b", i, resp_data, resp_id, resp_zero, e_d, exp_id);
                end
            end
            if (pending && i > acc_i) begin
                checks++;
                if (alu_op !== e_op || alu_ina !== e_a || alu_inb !== e_b) begin
                    errors++; $display("FAIL rnd_alu i=%0d got %h/%h/%h exp %h/%h/%h", i, alu_op, alu_ina, alu_inb, e_op, e_a, e_b);
                end
            end
            req0_valid = $urandom_range(0, 1) == 1;
            req1_valid = $urandom_range(0, 1) == 1;
            resp_ready = $urandom_range(0, 2) != 0;
            req0_op = ops[$urandom_range(0, 11)];
            req1_op = ops[$urandom_range(0, 11)];
            req0_a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            req0_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            req1_a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            req1_b = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            #1;
            any = !pending && (req0_valid || req1_valid);
            win = (req0_valid && req1_valid) ? (FIXED ? 1'b0 : !last_m) : req1_valid;
            checks++;
            if (req0_ready !== (any && !win) || req1_ready !== (any && win)) begin
                errors++; $display("FAIL rnd_ready i=%0d got r0=%b r1=%b exp any=%b win=%b", i, req0_ready, req1_ready, any, win);
            end
            if (ev && resp_ready) begin pending = 1'b0; last_m = exp_id; end
            if (any) begin
                pending = 1'b1; acc_i = i; exp_id = win;
                e_op = win ? req1_op : req0_op;
                e_a  = win ? req1_a : req0_a;
                e_b  = win ? req1_b : req0_b;
            end
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_stall();
        test_reset_mid();
        test_sra_drop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
